// File: rtl/core_ctrl_if.sv
// core_pkg: instruction classes reported by the decode stage.
// core_ctrl_if: control/handshake bundle between core_ctrl and the datapath.
package core_pkg;
  typedef enum logic [4:0] {
    INSTR_NOP,
    INSTR_LUI,
    INSTR_AUIPC,
    INSTR_JAL,
    INSTR_JALR,
    INSTR_BEQ,
    INSTR_BNE,
    INSTR_BLT,
    INSTR_BGE,
    INSTR_BLTU,
    INSTR_BGEU,
    INSTR_LB,
    INSTR_LH,
    INSTR_LW,
    INSTR_LBU,
    INSTR_LHU,
    INSTR_SB,
    INSTR_SH,
    INSTR_SW,
    INSTR_ADDI,
    INSTR_ALU,
    INSTR_ILLEGAL
  } rv32i_instr_e;
endpackage

interface core_ctrl_if;
  import core_pkg::*;

  logic         imem_req;
  logic         imem_ready;
  logic         ir_load;
  rv32i_instr_e instr_type;
  logic         rd_write_en;
  logic         dmem_req;
  logic         dmem_we;
  logic         dmem_ready;
  logic         rf_write;
  logic         pc_update;
  logic         retired;
  logic         halt;
  logic [1:0]   trap_cause;

  modport master (
    output imem_req,
    output ir_load,
    output dmem_req,
    output dmem_we,
    output rf_write,
    output pc_update,
    output retired,
    output halt,
    output trap_cause,
    input  imem_ready,
    input  instr_type,
    input  rd_write_en,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  ir_load,
    input  dmem_req,
    input  dmem_we,
    input  rf_write,
    input  pc_update,
    input  retired,
    input  halt,
    input  trap_cause,
    output imem_ready,
    output instr_type,
    output rd_write_en,
    output dmem_ready
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle RV32I control FSM with memory wait timeouts
// and sticky halt on illegal instructions or memory timeouts.
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  core_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int unsigned CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned TO_M1 =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] W_LAST = CW'(TO_M1);
  localparam bit TO_EN = (MEM_TIMEOUT > 0);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_wait;
  logic          r_is_load;
  logic          r_is_store;
  logic [1:0]    r_trap;
  logic [1:0]    w_trap;
  logic          w_wait;
  logic          w_to;
  logic          w_dec_ld;
  logic          w_dec_st;

  assign w_wait =
    ((r_state == S_FETCH) && !bus.imem_ready) ||
    ((r_state == S_MEM) && !bus.dmem_ready);

  // r_wait holds completed wait cycles; the current one is the last allowed
  assign w_to = TO_EN && (r_wait == W_LAST);

  always_comb begin
    w_dec_ld = 1'b0;
    w_dec_st = 1'b0;
    unique case (bus.instr_type)
      INSTR_LB, INSTR_LH, INSTR_LW,
      INSTR_LBU, INSTR_LHU: w_dec_ld = 1'b1;
      INSTR_SB, INSTR_SH,
      INSTR_SW: w_dec_st = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_trap = r_trap;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ready) begin
          w_next = S_DECODE;
        end else if (w_to) begin
          w_next = S_HALT;
          w_trap = 2'd2;
        end
      end
      S_DECODE: begin
        if (bus.instr_type == INSTR_ILLEGAL) begin
          w_next = S_HALT;
          w_trap = 2'd1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC:
        w_next = (r_is_load || r_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ready) begin
          w_next = S_WB;
        end else if (w_to) begin
          w_next = S_HALT;
          w_trap = 2'd3;
        end
      end
      S_WB:   w_next = S_FETCH;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_trap     <= 2'd0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trap  <= w_trap;
      if (w_wait) begin
        r_wait <= (&r_wait) ? r_wait : r_wait + CW'(1);
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_DECODE) begin
        r_is_load  <= w_dec_ld;
        r_is_store <= w_dec_st;
      end
    end
  end

  assign bus.imem_req   = (r_state == S_FETCH);
  assign bus.ir_load    = (r_state == S_FETCH) && bus.imem_ready;
  assign bus.dmem_req   = (r_state == S_MEM);
  assign bus.dmem_we    = (r_state == S_MEM) && r_is_store;
  assign bus.rf_write   = (r_state == S_WB) && bus.rd_write_en;
  assign bus.pc_update  = (r_state == S_WB);
  assign bus.retired    = (r_state == S_WB);
  assign bus.halt       = (r_state == S_HALT);
  assign bus.trap_cause = r_trap;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed plan of instructions expanded into per-cycle
// input vectors and expected outputs, checked every cycle.
module tb_core_ctrl;
  import core_pkg::*;

  typedef struct packed {
    logic         rst;
    logic         iready;
    logic         dready;
    rv32i_instr_e itype;
    logic         rdwe;
  } stim_t;

  typedef struct packed {
    logic       care;
    logic [9:0] o;
  } exp_t;

  localparam logic [9:0] O_IREQ = 10'b1000000000;
  localparam logic [9:0] O_ILD  = 10'b0100000000;
  localparam logic [9:0] O_DREQ = 10'b0010000000;
  localparam logic [9:0] O_DWE  = 10'b0001000000;
  localparam logic [9:0] O_RFW  = 10'b0000100000;
  localparam logic [9:0] O_PCU  = 10'b0000010000;
  localparam logic [9:0] O_RET  = 10'b0000001000;
  localparam logic [9:0] O_HLT  = 10'b0000000100;

  stim_t sq[$];
  exp_t  eq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_ret  = 0;
  int n_rfw  = 0;
  int n_halt = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  core_ctrl_if bus();

  core_ctrl #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic bit is_ld(rv32i_instr_e t);
    return t inside {INSTR_LB, INSTR_LH, INSTR_LW,
                     INSTR_LBU, INSTR_LHU};
  endfunction

  function automatic bit is_st(rv32i_instr_e t);
    return t inside {INSTR_SB, INSTR_SH, INSTR_SW};
  endfunction

  // inputs that must be ignored outside their owning state
  function automatic stim_t ns();
    stim_t s;
    s.rst    = 1'b0;
    s.iready = 1'b1;
    s.dready = 1'b1;
    s.itype  = INSTR_ILLEGAL;
    s.rdwe   = 1'b1;
    return s;
  endfunction

  task automatic push(stim_t s, logic c, logic [9:0] o);
    exp_t e;
    e.care = c;
    e.o    = o;
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic t_reset();
    stim_t s;
    s = ns();
    s.rst = 1'b1;
    push(s, 1'b0, '0);
  endtask

  task automatic t_idle();
    push(ns(), 1'b1, '0);
  endtask

  task automatic t_fetch(int d);
    stim_t s;
    for (int i = 0; i < d; i++) begin
      s = ns();
      s.iready = 1'b0;
      push(s, 1'b1, O_IREQ);
    end
    push(ns(), 1'b1, O_IREQ | O_ILD);
  endtask

  task automatic t_decode(rv32i_instr_e t);
    stim_t s;
    s = ns();
    s.itype = t;
    push(s, 1'b1, '0);
  endtask

  task automatic t_mwait(int n, bit st);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = ns();
      s.dready = 1'b0;
      push(s, 1'b1, O_DREQ | (st ? O_DWE : 10'd0));
    end
  endtask

  task automatic t_wb(bit rdwe);
    stim_t s;
    s = ns();
    s.rdwe = rdwe;
    push(s, 1'b1, (rdwe ? O_RFW : 10'd0) | O_PCU | O_RET);
  endtask

  task automatic t_halted(int n, logic [1:0] cause);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = ns();
      s.iready = i[0];
      s.rdwe   = i[1];
      push(s, 1'b1, O_HLT | {8'd0, cause});
    end
  endtask

  task automatic t_instr(rv32i_instr_e t, bit rdwe, int fd, int md);
    t_fetch(fd);
    t_decode(t);
    push(ns(), 1'b1, '0);
    if (is_ld(t) || is_st(t)) begin
      t_mwait(md, is_st(t));
      push(ns(), 1'b1, O_DREQ | (is_st(t) ? O_DWE : 10'd0));
    end
    t_wb(rdwe);
  endtask

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  initial begin
    int    b;
    int    cyc;
    stim_t s;
    exp_t  e;
    logic [9:0] got;

    bus.imem_ready  = 1'b0;
    bus.dmem_ready  = 1'b0;
    bus.instr_type  = INSTR_NOP;
    bus.rd_write_en = 1'b0;

    t_reset();
    t_reset();
    t_idle();

    b = eq.size();
    t_instr(INSTR_ADDI, 1'b1, 0, 0);
    chk("addi_len", eq.size() - b, 4);
    chk("addi_fetch", int'(eq[b].o), int'(O_IREQ | O_ILD));
    chk("addi_wb", int'(eq[b+3].o), int'(O_RFW | O_PCU | O_RET));

    b = eq.size();
    t_instr(INSTR_LW, 1'b1, 0, 3);
    chk("lw_len", eq.size() - b, 8);

    b = eq.size();
    t_instr(INSTR_SW, 1'b0, 0, 0);
    chk("sw_len", eq.size() - b, 5);
    chk("sw_mem", int'(eq[b+3].o), int'(O_DREQ | O_DWE));
    chk("sw_wb", int'(eq[b+4].o), int'(O_PCU | O_RET));

    t_instr(INSTR_JAL, 1'b1, 2, 0);
    t_instr(INSTR_BEQ, 1'b0, 3, 0);
    t_instr(INSTR_LBU, 1'b1, 1, 1);

    for (int i = 0; i < 4; i++) begin
      s = ns();
      s.iready = 1'b0;
      push(s, 1'b1, O_IREQ);
    end
    t_halted(5, 2'd2);

    t_reset();
    t_idle();
    t_fetch(0);
    t_decode(INSTR_LH);
    push(ns(), 1'b1, '0);
    t_mwait(4, 1'b0);
    t_halted(5, 2'd3);

    t_reset();
    t_idle();
    b = eq.size();
    t_fetch(1);
    t_decode(INSTR_ILLEGAL);
    chk("ill_len", eq.size() - b, 3);
    t_halted(20, 2'd1);

    t_reset();
    t_idle();
    t_fetch(0);
    t_decode(INSTR_LW);
    push(ns(), 1'b1, '0);
    t_mwait(2, 1'b0);
    t_reset();
    t_idle();
    t_instr(INSTR_ADDI, 1'b1, 0, 0);

    cyc = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      @(posedge clk);
      #1;
      rst             = s.rst;
      bus.imem_ready  = s.iready;
      bus.dmem_ready  = s.dready;
      bus.instr_type  = s.itype;
      bus.rd_write_en = s.rdwe;
      @(negedge clk);
      got = {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we,
             bus.rf_write, bus.pc_update, bus.retired, bus.halt,
             bus.trap_cause};
      if (e.care) begin
        n_chk++;
        if (got !== e.o) begin
          n_fail++;
          $display("FAIL cyc%0d outputs got=%b required=%b",
                   cyc, got, e.o);
        end
        if (bus.retired === 1'b1) n_ret++;
        if (bus.rf_write === 1'b1) n_rfw++;
        if (bus.halt === 1'b1) n_halt++;
      end
      cyc++;
    end

    chk("retired_total", n_ret, 7);
    chk("rf_write_total", n_rfw, 5);
    chk("halt_cycles", n_halt, 30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of wait cycles per memory request; 0 disables timeouts.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_ready  input  1  instruction word valid this cycle.
REQ-006 ir_load  output  1  one-cycle pulse; datapath latches the instruction word.
REQ-007 instr_type  input  rv32i_instr_e  decoded instruction class from the decode stage.
REQ-008 rd_write_en  input  1  decoder reports that the instruction writes rd.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 dmem_we  output  1  data request is a store; valid only with dmem_req.
REQ-011 dmem_ready  input  1  data access complete this cycle.
REQ-012 rf_write  output  1  register file write strobe.
REQ-013 pc_update  output  1  one-cycle pulse; datapath loads next PC.
REQ-014 retired  output  1  one-cycle pulse per completed instruction.
REQ-015 halt  output  1  sticky; core stopped.
REQ-016 trap_cause  output  2  0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and HALT.
REQ-018 IDLE SHALL assert no outputs and move to FETCH unconditionally in the next cycle.
REQ-019 FETCH SHALL assert imem_req; on imem_ready=1 it SHALL pulse ir_load in the same cycle and move to DECODE.
REQ-020 DECODE SHALL last one cycle and register is_load (LB/LH/LW/LBU/LHU) and is_store (SB/SH/SW) from instr_type.
REQ-021 In DECODE, instr_type==INSTR_ILLEGAL SHALL cause a move to HALT with trap_cause=1; otherwise the FSM SHALL move to EXECUTE.
REQ-022 EXECUTE SHALL last one cycle, then move to MEMORY if is_load or is_store, else to WRITEBACK.
REQ-023 MEMORY SHALL assert dmem_req, with dmem_we=is_store; on dmem_ready=1 it SHALL move to WRITEBACK.
REQ-024 WRITEBACK SHALL last one cycle, assert rf_write=rd_write_en and pulse pc_update and retired, then move to FETCH.
REQ-025 Branches, JAL, JALR, NOP, LUI and AUIPC SHALL follow the non-memory path; PC selection is the datapath's job.
REQ-026 Latency SHALL be 4 cycles per non-memory instruction and 5 per load/store when ready is returned in the same cycle as the request.
REQ-027 A wait counter SHALL clear on entry to FETCH or MEMORY and increment each cycle the request is high with ready low.
REQ-028 If MEM_TIMEOUT>0 and the MEM_TIMEOUT-th consecutive cycle passes without ready, the FSM SHALL move to HALT with trap_cause=2 (FETCH) or 3 (MEMORY).
REQ-029 Ready arriving in the same cycle the timeout would fire SHALL complete the access, not trap.
REQ-030 imem_ready outside FETCH and dmem_ready outside MEMORY SHALL be ignored.
REQ-031 HALT SHALL hold halt=1 and trap_cause constant, deassert all other outputs, and leave only on rst.
REQ-032 instr_type and rd_write_en SHALL be sampled only in DECODE and WRITEBACK respectively; other-cycle values have no effect.

Reset
REQ-033 rst=1 SHALL force state IDLE, wait counter 0, trap_cause 0, halt 0, and all strobes/requests 0 in the following cycle.
REQ-034 rst SHALL take priority over every transition, including mid-MEMORY and HALT; an in-flight request SHALL be dropped without completion.

Verification
REQ-035 ADDI, imem_ready tied 1 -> ir_load at cycle 1 after IDLE, rf_write+pc_update+retired at cycle 4, FETCH at cycle 5.
REQ-036 LW, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WRITEBACK with rf_write=1; 8 cycles total.
REQ-037 SW -> dmem_we=1 with dmem_req; WRITEBACK has rf_write=0 (rd_write_en=0), retired=1.
REQ-038 INSTR_ILLEGAL in DECODE -> halt=1, trap_cause=1 next cycle; no retired pulse; stays halted for 20 cycles; rst clears it.
REQ-039 MEM_TIMEOUT=4, imem_ready held 0 -> HALT, trap_cause=2 after 4 request cycles; repeat with ready on the 4th cycle -> no trap.
REQ-040 rst asserted during MEMORY wait -> dmem_req=0 next cycle, IDLE, then FETCH; no rf_write or retired pulse.
